// File: rtl/uart_bus_loader.sv
// Bootloader bus initiator: polls the UART register block, packs RX bytes (lo, hi) into words and writes program memory.
// Reads hold cs for 2 cycles, writes for 1, always followed by an idle gap; stalls indefinitely on RX/TX status bits.
module uart_bus_loader #(
  parameter int DATA_BUS_WIDTH = 16,
  parameter int ADDR_BUS_WIDTH = 11,
  parameter int UART_BASE      = 0,
  parameter int ECHO           = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  output logic                      o_cs,
  output logic                      o_w_r,
  output logic [ADDR_BUS_WIDTH-1:0] o_addr_bus,
  inout  wire  [DATA_BUS_WIDTH-1:0] io_data_bus,
  output logic                      o_mem_we,
  output logic [ADDR_BUS_WIDTH-1:0] o_mem_addr,
  output logic [DATA_BUS_WIDTH-1:0] o_mem_data,
  output logic                      o_busy,
  output logic                      o_done
);

  localparam logic [ADDR_BUS_WIDTH-1:0] REG_TX_DATA = ADDR_BUS_WIDTH'(UART_BASE + 0);
  localparam logic [ADDR_BUS_WIDTH-1:0] REG_TX_DONE = ADDR_BUS_WIDTH'(UART_BASE + 1);
  localparam logic [ADDR_BUS_WIDTH-1:0] REG_TX_RDY  = ADDR_BUS_WIDTH'(UART_BASE + 2);
  localparam logic [ADDR_BUS_WIDTH-1:0] REG_RX_DATA = ADDR_BUS_WIDTH'(UART_BASE + 3);
  localparam logic [ADDR_BUS_WIDTH-1:0] REG_RX_DONE = ADDR_BUS_WIDTH'(UART_BASE + 4);

  typedef enum logic [3:0] {
    S_IDLE, S_POLL, S_RDDATA, S_CLRRX, S_WRTX, S_SETRDY, S_TXPOLL,
    S_CLRTX, S_GAP, S_BYTE, S_MEMWR, S_DONE
  } state_t;

  state_t state_q, state_d, ret_q, ret_d;

  logic                      rd_ph_q, hi_q, hdr_q, done_q;
  logic [7:0]                lo_q, rx_q;
  logic [15:0]               remain_q, word_in;
  logic [ADDR_BUS_WIDTH-1:0] addr_q, addr;
  logic [DATA_BUS_WIDTH-1:0] word_q, wdata;
  logic                      cs, w_r, mem_we;
  logic                      unused_bus_bits;

  assign word_in         = {rx_q, lo_q};
  assign unused_bus_bits = ^io_data_bus[DATA_BUS_WIDTH-1:8];

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= S_IDLE;
      ret_q   <= S_IDLE;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
    end
  end

  // Every bus transaction exits through S_GAP (or a cs=0 state) so the UART can latch its status flags.
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    cs      = 1'b0;
    w_r     = 1'b0;
    addr    = '0;
    wdata   = '0;
    mem_we  = 1'b0;
    case (state_q)
      S_IDLE: if (i_start) state_d = S_POLL;
      S_POLL: begin
        cs   = 1'b1;
        addr = REG_RX_DONE;
        if (rd_ph_q) begin
          state_d = S_GAP;
          ret_d   = io_data_bus[0] ? S_RDDATA : S_POLL;
        end
      end
      S_RDDATA: begin
        cs   = 1'b1;
        addr = REG_RX_DATA;
        if (rd_ph_q) begin
          state_d = S_GAP;
          ret_d   = S_CLRRX;
        end
      end
      S_CLRRX: begin
        cs   = 1'b1;
        w_r  = 1'b1;
        addr = REG_RX_DONE;
        if (ECHO != 0) begin
          state_d = S_GAP;
          ret_d   = S_WRTX;
        end else begin
          state_d = S_BYTE;
        end
      end
      S_WRTX: begin
        cs      = 1'b1;
        w_r     = 1'b1;
        addr    = REG_TX_DATA;
        wdata   = DATA_BUS_WIDTH'(rx_q);
        state_d = S_GAP;
        ret_d   = S_SETRDY;
      end
      S_SETRDY: begin
        cs      = 1'b1;
        w_r     = 1'b1;
        addr    = REG_TX_RDY;
        wdata   = DATA_BUS_WIDTH'(1);
        state_d = S_GAP;
        ret_d   = S_TXPOLL;
      end
      S_TXPOLL: begin
        cs   = 1'b1;
        addr = REG_TX_DONE;
        if (rd_ph_q) begin
          state_d = S_GAP;
          ret_d   = io_data_bus[0] ? S_CLRTX : S_TXPOLL;
        end
      end
      S_CLRTX: begin
        cs      = 1'b1;
        w_r     = 1'b1;
        addr    = REG_TX_DONE;
        state_d = S_BYTE;
      end
      S_GAP: state_d = ret_q;
      S_BYTE: begin
        if (!hi_q)      state_d = S_POLL;
        else if (hdr_q) state_d = (word_in == 16'd0) ? S_DONE : S_POLL;
        else            state_d = S_MEMWR;
      end
      S_MEMWR: begin
        mem_we  = 1'b1;
        state_d = (remain_q == 16'd1) ? S_DONE : S_POLL;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rd_ph_q  <= 1'b0;
      hi_q     <= 1'b0;
      hdr_q    <= 1'b0;
      done_q   <= 1'b0;
      lo_q     <= '0;
      rx_q     <= '0;
      remain_q <= '0;
      addr_q   <= '0;
      word_q   <= '0;
    end else begin
      rd_ph_q <= cs && !w_r && !rd_ph_q;
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            done_q <= 1'b0;
            hdr_q  <= 1'b1;
            hi_q   <= 1'b0;
            addr_q <= '0;
          end
        end
        S_RDDATA: if (rd_ph_q) rx_q <= io_data_bus[7:0];
        S_BYTE: begin
          if (!hi_q) begin
            lo_q <= rx_q;
            hi_q <= 1'b1;
          end else begin
            hi_q <= 1'b0;
            if (hdr_q) begin
              hdr_q    <= 1'b0;
              remain_q <= word_in;
            end else begin
              word_q <= DATA_BUS_WIDTH'(word_in);
            end
          end
        end
        // Address counter wraps naturally when N exceeds the memory size.
        S_MEMWR: begin
          addr_q   <= addr_q + ADDR_BUS_WIDTH'(1);
          remain_q <= remain_q - 16'd1;
        end
        S_DONE:  done_q <= 1'b1;
        default: ;
      endcase
    end
  end

  assign o_cs        = cs;
  assign o_w_r       = w_r;
  assign o_addr_bus  = addr;
  assign io_data_bus = (cs && w_r) ? wdata : 'z;
  assign o_mem_we    = mem_we;
  assign o_mem_addr  = addr_q;
  assign o_mem_data  = word_q;
  assign o_busy      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign o_done      = done_q;

endmodule

// File: tb/tb_uart_bus_loader.sv
// Bench for uart_bus_loader: UART register-block model on the bus, protocol monitor, table and random loads.
module tb_uart_bus_loader;
  localparam int DW   = 16;
  localparam int AW   = 11;
  localparam int BASE = 0;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b0;
  logic          i_start = 1'b0;
  logic          o_cs, o_w_r, o_mem_we, o_busy, o_done;
  logic [AW-1:0] o_addr_bus, o_mem_addr;
  logic [DW-1:0] o_mem_data;
  wire  [DW-1:0] io_data_bus;

  uart_bus_loader #(.DATA_BUS_WIDTH(DW), .ADDR_BUS_WIDTH(AW), .UART_BASE(BASE), .ECHO(1)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
    .o_cs(o_cs), .o_w_r(o_w_r), .o_addr_bus(o_addr_bus), .io_data_bus(io_data_bus),
    .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
    .o_busy(o_busy), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  // UART register block model (state changes on negedge, so reads are stable at the DUT's sampling edge)
  logic          rx_done_r = 1'b0, tx_done_r = 1'b0;
  logic [7:0]    rx_data_r = 8'h0, tx_data_r = 8'h0;
  logic [7:0]    rx_mem [0:1023];
  logic [7:0]    tx_log [0:1023];
  logic [AW-1:0] got_addr [0:1023];
  logic [DW-1:0] got_data [0:1023];
  int            rx_wr = 0, rx_rd = 0, rx_wait = 0;
  int            tx_wr = 0, tx_cnt = 0, txclr_cnt = 0, got_wr = 0;
  bit            tx_pend = 1'b0;
  int            run = 0;
  bit            run_wr = 1'b0;
  logic [AW-1:0] run_addr = '0;
  int            prot_errs = 0;
  logic [AW-1:0] off;
  logic [DW-1:0] rd_val;

  assign off = o_addr_bus - AW'(BASE);

  always_comb begin
    rd_val = 16'hDEAD;
    case (int'(off))
      1: rd_val = {15'h52D2, tx_done_r};
      3: rd_val = {8'hC3, rx_data_r};
      4: rd_val = {15'h52D2, rx_done_r};
      default: rd_val = 16'hDEAD;
    endcase
  end

  assign io_data_bus = (o_cs && !o_w_r) ? rd_val : 'z;

  task automatic perr(input string msg);
    prot_errs++;
    $display("FAIL proto %s", msg);
  endtask

  always @(negedge i_clk) begin
    if (!i_rst) begin
      rx_done_r = 1'b0; tx_done_r = 1'b0; tx_cnt = 0; tx_pend = 1'b0;
      rx_rd = rx_wr; rx_wait = 0; run = 0;
    end else begin
      if (o_cs) begin
        if (run == 0) begin
          run_wr = o_w_r; run_addr = o_addr_bus;
        end else if (o_w_r !== run_wr || o_addr_bus !== run_addr) begin
          perr($sformatf("cs run changed: got w_r=%0b addr=%0h required w_r=%0b addr=%0h", o_w_r, o_addr_bus, run_wr, run_addr));
        end
        run++;
        if (!o_w_r) begin
          if (io_data_bus !== rd_val) perr($sformatf("read bus: got %h required %h", io_data_bus, rd_val));
        end else begin
          case (int'(off))
            0: tx_data_r = io_data_bus[7:0];
            1: begin
              if (io_data_bus !== 16'h0) perr($sformatf("tx_done clear data: got %h required 0", io_data_bus));
              tx_done_r = 1'b0; txclr_cnt++;
            end
            2: begin
              if (io_data_bus !== 16'h1) perr($sformatf("tx_rdy data: got %h required 1", io_data_bus));
              tx_cnt = int'($urandom_range(1, 6));
            end
            4: begin
              if (io_data_bus !== 16'h0) perr($sformatf("rx_done clear data: got %h required 0", io_data_bus));
              rx_done_r = 1'b0;
            end
            default: perr($sformatf("write address: got %h required 0,1,2 or 4", off));
          endcase
        end
      end else if (run > 0) begin
        if (run != (run_wr ? 1 : 2)) perr($sformatf("cs length w_r=%0b: got %0d required %0d", run_wr, run, run_wr ? 1 : 2));
        run = 0;
      end
      if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) begin
          tx_log[tx_wr] = tx_data_r; tx_wr++; tx_pend = 1'b1;
        end
      end
      if (!o_cs) begin
        if (tx_pend) begin
          tx_done_r = 1'b1; tx_pend = 1'b0;
        end
        if (rx_wait > 0) rx_wait--;
        else if (!rx_done_r && rx_rd < rx_wr) begin
          rx_data_r = rx_mem[rx_rd]; rx_rd++; rx_done_r = 1'b1;
          rx_wait = int'($urandom_range(0, 6));
        end
      end
      if (o_mem_we) begin
        got_addr[got_wr] = o_mem_addr; got_data[got_wr] = o_mem_data; got_wr++;
      end
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge i_clk); i_start = 1'b1;
    @(negedge i_clk); i_start = 1'b0;
  endtask

  // Reference: stream = N lo, N hi, then each word lo/hi; echo = same stream; writes at k mod 2^AW.
  task automatic run_load(input int n, input logic [7:0][15:0] w, input int exp_we,
                          input logic [7:0][15:0] exp_d, input bit poke);
    int g0, t0, c0;
    bit ok;
    logic [7:0]  eb[$];
    logic [15:0] hw;
    g0 = got_wr; t0 = tx_wr; c0 = txclr_cnt;
    hw = 16'(n);
    eb.push_back(hw[7:0]); eb.push_back(hw[15:8]);
    for (int k = 0; k < n; k++) begin
      eb.push_back(w[k][7:0]); eb.push_back(w[k][15:8]);
    end
    foreach (eb[i]) begin
      rx_mem[rx_wr] = eb[i]; rx_wr++;
    end
    pulse_start();
    chk("busy after start", 32'(o_busy), 32'd1);
    chk("done cleared by start", 32'(o_done), 32'd0);
    ok = 1'b0;
    for (int c = 0; c < 20000 && !ok; c++) begin
      @(negedge i_clk);
      if (poke) i_start = (c == 100);
      if (o_done && !o_busy) ok = 1'b1;
    end
    i_start = 1'b0;
    chk("load completes", 32'(ok), 32'd1);
    chk("busy low at done", 32'(o_busy), 32'd0);
    chk("mem write count", 32'(got_wr - g0), 32'(exp_we));
    for (int k = 0; k < exp_we && k < got_wr - g0; k++) begin
      chk($sformatf("mem addr %0d", k), 32'(got_addr[g0 + k]), 32'(k % (1 << AW)));
      chk($sformatf("mem data %0d", k), 32'(got_data[g0 + k]), 32'(exp_d[k]));
    end
    chk("echo byte count", 32'(tx_wr - t0), 32'(eb.size()));
    for (int i = 0; i < eb.size() && i < tx_wr - t0; i++)
      chk($sformatf("echo byte %0d", i), 32'(tx_log[t0 + i]), 32'(eb[i]));
    chk("tx_done clears", 32'(txclr_cnt - c0), 32'(eb.size()));
  endtask

  typedef struct {
    int               n;
    logic [7:0][15:0] w;
    int               exp_we;
    logic [7:0][15:0] exp_d;
    bit               poke;
  } vec_t;

  vec_t tbl[4];

  initial begin
    bit               ok;
    int               n, g0;
    logic [7:0][15:0] rw;

    tbl[0].n = 2; tbl[0].w = '0; tbl[0].w[0] = 16'h1234; tbl[0].w[1] = 16'hABCD;
    tbl[0].exp_we = 2; tbl[0].exp_d = '0; tbl[0].exp_d[0] = 16'h1234; tbl[0].exp_d[1] = 16'hABCD; tbl[0].poke = 1'b0;
    tbl[1].n = 0; tbl[1].w = '0; tbl[1].exp_we = 0; tbl[1].exp_d = '0; tbl[1].poke = 1'b0;
    tbl[2].n = 1; tbl[2].w = '0; tbl[2].w[0] = 16'hAA55;
    tbl[2].exp_we = 1; tbl[2].exp_d = '0; tbl[2].exp_d[0] = 16'hAA55; tbl[2].poke = 1'b0;
    tbl[3].n = 3; tbl[3].w = '0; tbl[3].w[0] = 16'h0000; tbl[3].w[1] = 16'hFFFF; tbl[3].w[2] = 16'h00FF;
    tbl[3].exp_we = 3; tbl[3].exp_d = '0; tbl[3].exp_d[0] = 16'h0000; tbl[3].exp_d[1] = 16'hFFFF;
    tbl[3].exp_d[2] = 16'h00FF; tbl[3].poke = 1'b1;

    repeat (2) @(negedge i_clk);
    chk("reset cs", 32'(o_cs), 32'd0);
    chk("reset w_r", 32'(o_w_r), 32'd0);
    chk("reset busy", 32'(o_busy), 32'd0);
    chk("reset done", 32'(o_done), 32'd0);
    chk("reset mem_we", 32'(o_mem_we), 32'd0);
    chk("reset mem_addr", 32'(o_mem_addr), 32'd0);
    chk("reset mem_data", 32'(o_mem_data), 32'd0);
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    chk("idle without start", 32'(o_cs), 32'd0);

    for (int t = 0; t < 4; t++)
      run_load(tbl[t].n, tbl[t].w, tbl[t].exp_we, tbl[t].exp_d, tbl[t].poke);

    // Asynchronous reset in the middle of a load, during a bus write
    rw = '0; rw[0] = 16'h1111; rw[1] = 16'h2222; rw[2] = 16'h3333; rw[3] = 16'h4444;
    rx_mem[rx_wr] = 8'h04; rx_wr++; rx_mem[rx_wr] = 8'h00; rx_wr++;
    for (int k = 0; k < 4; k++) begin
      rx_mem[rx_wr] = rw[k][7:0]; rx_wr++; rx_mem[rx_wr] = rw[k][15:8]; rx_wr++;
    end
    g0 = got_wr;
    pulse_start();
    ok = 1'b0;
    for (int c = 0; c < 20000 && !ok; c++) begin
      @(negedge i_clk);
      if (got_wr > g0) ok = 1'b1;
    end
    chk("first write before reset", 32'(ok), 32'd1);
    ok = 1'b0;
    for (int c = 0; c < 2000 && !ok; c++) begin
      @(posedge i_clk); #1;
      if (o_cs && o_w_r) ok = 1'b1;
    end
    chk("found bus write", 32'(ok), 32'd1);
    i_rst = 1'b0;
    #1;
    chk("async reset cs", 32'(o_cs), 32'd0);
    chk("async reset busy", 32'(o_busy), 32'd0);
    chk("async reset mem_we", 32'(o_mem_we), 32'd0);
    repeat (3) @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    chk("post-reset busy", 32'(o_busy), 32'd0);
    chk("post-reset done", 32'(o_done), 32'd0);
    chk("post-reset cs", 32'(o_cs), 32'd0);
    run_load(tbl[0].n, tbl[0].w, tbl[0].exp_we, tbl[0].exp_d, 1'b0);

    // Random loads against the reference rules
    for (int r = 0; r < 6; r++) begin
      n = int'($urandom_range(0, 6));
      rw = '0;
      for (int k = 0; k < n; k++) rw[k] = 16'($urandom);
      run_load(n, rw, n, rw, 1'b0);
    end

    chk("protocol violations", 32'(prot_errs), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
